xif_copro_seq: RTL and testbench

// Parametrised eXtension-interface coprocessor model for the core testbench.
// - Sits on the core's X-interface issue/commit/result channels, next to the memory model.
// - Actively accepts custom-0 instructions, computes results, holds up to DEPTH speculative

---
 rtl/xif_copro_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_xif_copro_seq.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_copro_seq.sv
// X-interface coprocessor model: accepts custom-0 instructions, holds them speculatively in an
// in-order circular queue, and retires committed entries after a fixed latency.
module xif_copro_seq #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned X_NUM_RS = 3,
  parameter int unsigned LATENCY  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [31:0]                  issue_instr_i,
  input  logic [ID_WIDTH-1:0]          issue_id_i,
  input  logic [32*X_NUM_RS-1:0]       issue_rs_i,
  input  logic [X_NUM_RS-1:0]          issue_rs_valid_i,
  output logic                         issue_accept_o,
  output logic                         issue_writeback_o,
  input  logic                         commit_valid_i,
  input  logic [ID_WIDTH-1:0]          commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [ID_WIDTH-1:0]          result_id_o,
  output logic [31:0]                  result_data_o,
  output logic [4:0]                   result_rd_o,
  output logic                         result_we_o,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [PW-1:0] LastPtr  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LatCnt   = LW'(LATENCY);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [6:0]    OpCustom0 = 7'b0001011;

  // Entry storage
  logic                r_vld  [DEPTH];
  logic [ID_WIDTH-1:0] r_id   [DEPTH];
  logic [4:0]          r_rd   [DEPTH];
  logic [31:0]         r_data [DEPTH];
  logic                r_com  [DEPTH];
  logic                r_kil  [DEPTH];
  logic [LW-1:0]       r_cnt  [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic [31:0]   w_rs1;
  logic [31:0]   w_rs2;
  logic [31:0]   w_rs3;
  logic [2:0]    w_funct3;
  logic [31:0]   w_result;
  logic          w_f3_ok;
  logic          w_legal;
  logic          w_dup;
  logic          w_chit;
  logic [PW-1:0] w_cidx;
  logic          w_copen;
  logic          w_ready;
  logic          w_hs;
  logic          w_accept;
  logic          w_cmt_old;
  logic          w_cmt_new;
  logic          w_err_set;
  logic          w_head_rdy;
  logic          w_pop;
  logic          w_push;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;
  logic          w_unused;

  // Operand unpacking; a two-operand interface reads rs3 as zero
  assign w_rs1 = issue_rs_i[31:0];
  assign w_rs2 = issue_rs_i[63:32];

  generate
    if (X_NUM_RS >= 3) begin : g_rs3
      assign w_rs3 = issue_rs_i[95:64];
    end else begin : g_no_rs3
      assign w_rs3 = '0;
    end
  endgenerate

  assign w_funct3 = issue_instr_i[14:12];
  assign w_unused = ^issue_instr_i[31:15];

  always_comb begin
    w_result = '0;
    w_f3_ok  = 1'b0;
    case (w_funct3)
      3'b000: begin
        w_result = w_rs1 + w_rs2 + w_rs3;
        w_f3_ok  = 1'b1;
      end
      3'b001: begin
        w_result = w_rs1 ^ w_rs2 ^ w_rs3;
        w_f3_ok  = 1'b1;
      end
      3'b010: begin
        w_result = (w_rs1 < w_rs2) ? w_rs1 : w_rs2;
        w_f3_ok  = 1'b1;
      end
      default: begin
        w_result = '0;
        w_f3_ok  = 1'b0;
      end
    endcase
  end

  assign w_legal = (issue_instr_i[6:0] == OpCustom0) && w_f3_ok;

  // Ids are unique among valid entries, so at most one entry can match each lookup
  always_comb begin
    w_dup  = 1'b0;
    w_chit = 1'b0;
    w_cidx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_id[i] == issue_id_i)) begin
        w_dup = 1'b1;
      end
      if (r_vld[i] && (r_id[i] == commit_id_i)) begin
        w_chit = 1'b1;
        w_cidx = PW'(i);
      end
    end
  end

  assign w_copen  = !r_com[w_cidx] && !r_kil[w_cidx];

  assign w_ready  = (r_count < DepthCnt) && (&issue_rs_valid_i);
  assign w_hs     = issue_valid_i && w_ready && !rst_i;
  assign w_accept = w_hs && w_legal && !w_dup;
  assign w_push   = w_accept;

  // A commit for an id that is being issued this very cycle lands on the new entry
  assign w_cmt_old = commit_valid_i && w_chit && w_copen;
  assign w_cmt_new = commit_valid_i && !w_chit && w_accept && (issue_id_i == commit_id_i);
  assign w_err_set = (w_hs && w_legal && w_dup) ||
                     (commit_valid_i && !w_cmt_old && !w_cmt_new);

  assign w_head_rdy = r_vld[r_head] && r_com[r_head] && (r_cnt[r_head] == '0);
  assign w_pop      = r_vld[r_head] && (r_kil[r_head] || (w_head_rdy && result_ready_i));

  assign w_head_nxt = (r_head == LastPtr) ? '0 : r_head + PW'(1);
  assign w_tail_nxt = (r_tail == LastPtr) ? '0 : r_tail + PW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_id[i]   <= '0;
        r_rd[i]   <= '0;
        r_data[i] <= '0;
        r_com[i]  <= 1'b0;
        r_kil[i]  <= 1'b0;
        r_cnt[i]  <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_vld[i] && r_com[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - LW'(1);
        end
      end

      if (w_cmt_old) begin
        if (commit_kill_i) begin
          r_kil[w_cidx] <= 1'b1;
        end else begin
          r_com[w_cidx] <= 1'b1;
          r_cnt[w_cidx] <= LatCnt;
        end
      end

      // The tail slot is always free when pushing, so it never collides with w_cidx
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_id[r_tail]   <= issue_id_i;
        r_rd[r_tail]   <= issue_instr_i[11:7];
        r_data[r_tail] <= w_result;
        r_com[r_tail]  <= w_cmt_new && !commit_kill_i;
        r_kil[r_tail]  <= w_cmt_new && commit_kill_i;
        r_cnt[r_tail]  <= LatCnt;
        r_tail         <= w_tail_nxt;
      end

      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= w_head_nxt;
      end

      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign issue_ready_o     = w_ready;
  assign issue_accept_o    = w_accept;
  assign issue_writeback_o = w_accept;

  assign result_valid_o = w_head_rdy;
  assign result_we_o    = w_head_rdy;
  assign result_id_o    = w_head_rdy ? r_id[r_head]   : '0;
  assign result_data_o  = w_head_rdy ? r_data[r_head] : '0;
  assign result_rd_o    = w_head_rdy ? r_rd[r_head]   : '0;

  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule

// File: tb/tb_xif_copro_seq.sv
// Bench for xif_copro_seq: directed scenarios plus randomized traffic, all checked against a
// queue-based model that tracks commit times instead of countdowns.
module tb_xif_copro_seq;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ID_WIDTH = 4;
  localparam int unsigned X_NUM_RS = 3;
  localparam int unsigned LATENCY  = 2;
  localparam int unsigned CW       = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    issue_valid;
  logic                    issue_ready;
  logic [31:0]             instr;
  logic [ID_WIDTH-1:0]     issue_id;
  logic [32*X_NUM_RS-1:0]  rs;
  logic [X_NUM_RS-1:0]     rs_valid;
  logic                    issue_accept;
  logic                    issue_writeback;
  logic                    commit_valid;
  logic [ID_WIDTH-1:0]     commit_id;
  logic                    commit_kill;
  logic                    result_valid;
  logic                    result_ready;
  logic [ID_WIDTH-1:0]     result_id;
  logic [31:0]             result_data;
  logic [4:0]              result_rd;
  logic                    result_we;
  logic [CW-1:0]           outstanding;
  logic                    err;

  xif_copro_seq #(
    .DEPTH    (DEPTH),
    .ID_WIDTH (ID_WIDTH),
    .X_NUM_RS (X_NUM_RS),
    .LATENCY  (LATENCY)
  ) u_dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .issue_valid_i     (issue_valid),
    .issue_ready_o     (issue_ready),
    .issue_instr_i     (instr),
    .issue_id_i        (issue_id),
    .issue_rs_i        (rs),
    .issue_rs_valid_i  (rs_valid),
    .issue_accept_o    (issue_accept),
    .issue_writeback_o (issue_writeback),
    .commit_valid_i    (commit_valid),
    .commit_id_i       (commit_id),
    .commit_kill_i     (commit_kill),
    .result_valid_o    (result_valid),
    .result_ready_i    (result_ready),
    .result_id_o       (result_id),
    .result_data_o     (result_data),
    .result_rd_o       (result_rd),
    .result_we_o       (result_we),
    .outstanding_o     (outstanding),
    .err_o             (err)
  );

  typedef struct {
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rd;
    logic [31:0]         data;
    bit                  com;
    bit                  kil;
    int                  ccyc;
  } ent_t;

  ent_t q[$];
  bit   m_err;
  int   cyc;
  int   n_vec;
  int   n_mis;

  logic [ID_WIDTH-1:0] got_ids[$];
  logic [31:0]         got_data[$];

  logic                s_rv;
  logic                s_acc;
  logic                s_ready;
  logic                s_err;
  logic [31:0]         s_data;
  logic [ID_WIDTH-1:0] s_id;
  logic [4:0]          s_rd;
  logic [CW-1:0]       s_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_id(input logic [ID_WIDTH-1:0] id);
    foreach (q[i]) begin
      if (q[i].id == id) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [95:0] ops);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    a = ops[31:0];
    b = ops[63:32];
    c = ops[95:64];
    case (f3)
      3'b000:  return a + b + c;
      3'b001:  return a ^ b ^ c;
      3'b010:  return (a < b) ? a : b;
      default: return 32'h0;
    endcase
  endfunction

  // A committed entry becomes visible LATENCY cycles after the edge that took the commit
  function automatic bit head_elig();
    if (q.size() == 0) return 1'b0;
    return q[0].com && (cyc >= q[0].ccyc + int'(LATENCY));
  endfunction

  // Starts just after a rising edge with inputs settled; checks mid-cycle, then advances.
  task automatic cycle();
    bit   m_ready;
    bit   m_legal;
    bit   m_dup;
    bit   m_hs;
    bit   m_acc;
    bit   m_rv;
    bit   m_pop;
    int   hit;
    ent_t ne;
    #4;
    s_rv    = result_valid;
    s_acc   = issue_accept;
    s_ready = issue_ready;
    s_err   = err;
    s_data  = result_data;
    s_id    = result_id;
    s_rd    = result_rd;
    s_out   = outstanding;
    m_ready = (q.size() < DEPTH) && (&rs_valid);
    m_legal = (instr[6:0] == 7'b0001011) && (instr[14:12] inside {3'b000, 3'b001, 3'b010});
    m_dup   = (find_id(issue_id) >= 0);
    m_hs    = issue_valid && m_ready;
    m_acc   = m_hs && m_legal && !m_dup;
    m_rv    = head_elig();
    if (!rst) begin
      check("issue_ready", s_ready, m_ready);
      check("accept", s_acc, m_acc);
      check("writeback", issue_writeback, m_acc);
      check("result_valid", s_rv, m_rv);
      check("result_we", result_we, m_rv);
      check("outstanding", s_out, q.size());
      check("err", s_err, m_err);
      if (m_rv) begin
        check("result_id", s_id, q[0].id);
        check("result_data", s_data, q[0].data);
        check("result_rd", s_rd, q[0].rd);
      end
      if (s_rv && result_ready) begin
        got_ids.push_back(s_id);
        got_data.push_back(s_data);
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      m_pop = (q.size() > 0) && (q[0].kil || (m_rv && result_ready));
      ne = '{id: issue_id, rd: instr[11:7], data: ref_result(instr[14:12], rs),
             com: 1'b0, kil: 1'b0, ccyc: 0};
      if (commit_valid) begin
        hit = find_id(commit_id);
        if (hit >= 0 && !q[hit].com && !q[hit].kil) begin
          if (commit_kill) q[hit].kil = 1'b1;
          else begin
            q[hit].com  = 1'b1;
            q[hit].ccyc = cyc;
          end
        end else if (hit < 0 && m_acc && issue_id == commit_id) begin
          if (commit_kill) ne.kil = 1'b1;
          else begin
            ne.com  = 1'b1;
            ne.ccyc = cyc;
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_hs && m_legal && m_dup) m_err = 1'b1;
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back(ne);
    end
    #1;
  endtask

  task automatic idle();
    rst          = 1'b0;
    issue_valid  = 1'b0;
    instr        = '0;
    issue_id     = '0;
    rs           = '0;
    rs_valid     = '1;
    commit_valid = 1'b0;
    commit_id    = '0;
    commit_kill  = 1'b0;
    result_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    got_ids.delete();
    got_data.delete();
  endtask

  task automatic issue(input int id, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [6:0] op);
    logic [31:0] w;
    w            = $urandom;
    w[6:0]       = op;
    w[11:7]      = rd;
    w[14:12]     = f3;
    instr        = w;
    issue_valid  = 1'b1;
    issue_id     = ID_WIDTH'(id);
    rs           = {c, b, a};
    rs_valid     = '1;
  endtask

  task automatic commit(input int id, input bit kill);
    commit_valid = 1'b1;
    commit_id    = ID_WIDTH'(id);
    commit_kill  = kill;
  endtask

  localparam logic [6:0] Op0 = 7'b0001011;

  logic [31:0] held;

  initial begin
    n_vec = 0;
    n_mis = 0;
    cyc   = 0;
    m_err = 1'b0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    cycle();
    check("rst_valid", s_rv, 0);
    check("rst_data", s_data, 0);
    check("rst_id", s_id, 0);
    check("rst_rd", s_rd, 0);
    check("rst_out", s_out, 0);
    check("rst_err", s_err, 0);
    check("rst_acc", s_acc, 0);

    // Basic add with latency
    issue(5, 3'b000, 5'd7, 32'd1, 32'd2, 32'd3, Op0);
    cycle();
    check("t1_accept", s_acc, 1);
    idle();
    commit(5, 1'b0);
    cycle();
    idle();
    cycle();
    check("t1_lat0", s_rv, 0);
    cycle();
    check("t1_lat1", s_rv, 0);
    cycle();
    check("t1_valid", s_rv, 1);
    check("t1_data", s_data, 6);
    check("t1_id", s_id, 5);
    check("t1_rd", s_rd, 7);

    // Fill, then commit in reverse order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(i, 3'b000, 5'(i + 1), $urandom, $urandom, $urandom, Op0);
      cycle();
    end
    idle();
    cycle();
    check("t2_out", s_out, 4);
    check("t2_ready", s_ready, 0);
    for (int i = 3; i >= 0; i--) begin
      commit(i, 1'b0);
      cycle();
    end
    idle();
    for (int i = 0; i < 8; i++) cycle();
    check("t2_count", got_ids.size(), 4);
    for (int i = 0; i < 4 && i < got_ids.size(); i++) check("t2_order", got_ids[i], i);

    // Kill one, commit the other
    do_reset();
    issue(1, 3'b001, 5'd1, $urandom, $urandom, $urandom, Op0);
    cycle();
    issue(2, 3'b010, 5'd2, $urandom, $urandom, $urandom, Op0);
    cycle();
    idle();
    commit(1, 1'b1);
    cycle();
    commit(2, 1'b0);
    cycle();
    idle();
    for (int i = 0; i < 8; i++) cycle();
    check("t3_count", got_ids.size(), 1);
    if (got_ids.size() > 0) check("t3_id", got_ids[0], 2);
    check("t3_out", s_out, 0);

    // Unknown commit id; duplicate issue id
    do_reset();
    commit(9, 1'b0);
    cycle();
    idle();
    cycle();
    check("t4_err_commit", s_err, 1);
    do_reset();
    issue(4, 3'b000, 5'd4, 32'd1, 32'd1, 32'd1, Op0);
    cycle();
    issue(4, 3'b000, 5'd4, 32'd2, 32'd2, 32'd2, Op0);
    cycle();
    check("t4_dup_acc", s_acc, 0);
    idle();
    for (int i = 0; i < 3; i++) cycle();
    check("t4_err_dup", s_err, 1);

    // XOR, illegal funct3, wrong opcode
    do_reset();
    issue(6, 3'b001, 5'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, Op0);
    cycle();
    idle();
    commit(6, 1'b0);
    cycle();
    idle();
    for (int i = 0; i < 4; i++) cycle();
    check("t5_count", got_data.size(), 1);
    if (got_data.size() > 0) check("t5_xor", got_data[0], 32'h0FF00FF0);
    issue(7, 3'b111, 5'd3, 32'd1, 32'd2, 32'd3, Op0);
    cycle();
    check("t5_f3_111", s_acc, 0);
    issue(8, 3'b000, 5'd3, 32'd1, 32'd2, 32'd3, 7'b0110011);
    cycle();
    check("t5_opcode", s_acc, 0);

    // Backpressure stability, then reset mid-queue
    do_reset();
    issue(1, 3'b000, 5'd9, $urandom, $urandom, $urandom, Op0);
    cycle();
    issue(2, 3'b001, 5'd10, $urandom, $urandom, $urandom, Op0);
    cycle();
    idle();
    result_ready = 1'b0;
    commit(1, 1'b0);
    cycle();
    commit(2, 1'b0);
    cycle();
    idle();
    result_ready = 1'b0;
    for (int i = 0; i < 2; i++) cycle();
    held = s_data;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t6_hold_valid", s_rv, 1);
      check("t6_hold_data", s_data, held);
      check("t6_hold_id", s_id, 1);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("t6_rst_valid", s_rv, 0);
    check("t6_rst_out", s_out, 0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] w;
      w            = $urandom;
      if ($urandom_range(0, 9) != 0) w[6:0] = Op0;
      w[14:12]     = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      instr        = w;
      issue_valid  = ($urandom_range(0, 9) < 6);
      issue_id     = ID_WIDTH'($urandom_range(0, 7));
      rs           = {$urandom, $urandom, $urandom};
      rs_valid     = ($urandom_range(0, 9) == 0) ? X_NUM_RS'($urandom) : '1;
      commit_valid = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 4) != 0) begin
        commit_id = q[$urandom_range(0, q.size() - 1)].id;
      end else begin
        commit_id = ID_WIDTH'($urandom);
      end
      commit_kill  = ($urandom_range(0, 3) == 0);
      result_ready = ($urandom_range(0, 9) < 7);
      rst          = ($urandom_range(0, 149) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
